// File: rtl/sdram_init_refresh_ctrl.sv
// SDRAM power-up init sequencer and periodic auto-refresh scheduler.
// Owns the command bus during init; afterwards it requests the bus once per refresh interval.
module sdram_init_refresh_ctrl #(
  parameter int          INIT_WAIT  = 20000,
  parameter int          T_RP       = 2,
  parameter int          T_RFC      = 7,
  parameter int          T_MRD      = 2,
  parameter int          REF_PERIOD = 780,
  parameter logic [12:0] MODE_REG   = 13'h0037
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ref_ack,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  output logic        init_done,
  output logic        ref_req,
  output logic        ref_busy,
  output logic        ref_overflow
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  localparam int CNT_W = $clog2(INIT_WAIT + T_RP + T_RFC + T_MRD + 2);
  localparam int REF_W = $clog2(REF_PERIOD + 1);

  // The reset cycle itself is not part of the power-up wait, hence no -1 here.
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(INIT_WAIT);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RFC_LAST = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] MRD_LAST = CNT_W'(T_MRD - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_PERIOD - 1);

  typedef enum logic [3:0] {
    WAIT_PWR, PRE, WAIT_RP, AREF1, WAIT_RFC1, AREF2, WAIT_RFC2,
    LMR, WAIT_MRD, IDLE, REF_CMD, REF_WAIT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [REF_W-1:0] ref_cnt;
  logic             timer_en;
  logic [1:0]       owed;
  logic [1:0]       owed_nxt;
  logic             tick;
  logic             grant;
  logic             lost;

  // Handshake: a refresh is granted in the cycle where ref_req and ref_ack are both high;
  // ref_req only rises in IDLE, so ref_ack at any other time has no effect.
  always_comb begin
    tick     = timer_en && (ref_cnt == REF_LAST);
    grant    = ref_req && ref_ack;
    owed_nxt = owed;
    lost     = 1'b0;
    if (tick && !grant) begin
      if (owed == 2'd3) lost = 1'b1;
      else              owed_nxt = owed + 2'd1;
    end else if (grant && !tick) begin
      owed_nxt = owed - 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_PWR:  if (cnt == PWR_LAST) state_nxt = PRE;
      PRE:       state_nxt = WAIT_RP;
      WAIT_RP:   if (cnt == RP_LAST)  state_nxt = AREF1;
      AREF1:     state_nxt = WAIT_RFC1;
      WAIT_RFC1: if (cnt == RFC_LAST) state_nxt = AREF2;
      AREF2:     state_nxt = WAIT_RFC2;
      WAIT_RFC2: if (cnt == RFC_LAST) state_nxt = LMR;
      LMR:       state_nxt = WAIT_MRD;
      WAIT_MRD:  if (cnt == MRD_LAST) state_nxt = IDLE;
      IDLE:      if (grant)           state_nxt = REF_CMD;
      REF_CMD:   state_nxt = REF_WAIT;
      REF_WAIT:  if (cnt == RFC_LAST) state_nxt = IDLE;
      default:   state_nxt = WAIT_PWR;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= WAIT_PWR;
      cnt          <= '0;
      ref_cnt      <= '0;
      timer_en     <= 1'b0;
      owed         <= 2'd0;
      sdram_cmd    <= CMD_NOP;
      sdram_ba     <= 2'd0;
      sdram_addr   <= 13'd0;
      init_done    <= 1'b0;
      ref_req      <= 1'b0;
      ref_busy     <= 1'b0;
      ref_overflow <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= (state_nxt != state || state_nxt == IDLE) ? '0 : cnt + 1'b1;
      timer_en     <= timer_en | (state_nxt == IDLE);
      if (timer_en) ref_cnt <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + 1'b1;
      owed         <= owed_nxt;
      ref_overflow <= ref_overflow | lost;
      init_done    <= init_done | (state_nxt == IDLE);
      ref_req      <= (owed_nxt != 2'd0) && (state_nxt == IDLE);
      ref_busy     <= (state_nxt == REF_CMD) || (state_nxt == REF_WAIT);
      sdram_cmd    <= CMD_NOP;
      sdram_ba     <= 2'd0;
      sdram_addr   <= 13'd0;
      case (state_nxt)
        PRE: begin
          sdram_cmd  <= CMD_PRE;
          sdram_addr <= 13'h0400;
        end
        AREF1, AREF2, REF_CMD: sdram_cmd <= CMD_AREF;
        LMR: begin
          sdram_cmd  <= CMD_LMR;
          sdram_addr <= MODE_REG;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_init_refresh_ctrl.sv
// Bench for sdram_init_refresh_ctrl: cycle-numbered reference model of the init schedule
// and refresh bookkeeping, plus scenario tasks with fixed-cycle expectations.
module tb_sdram_init_refresh_ctrl;
  localparam int IW = 10, TRP = 2, TRFC = 7, TMRD = 2, P = 50;
  localparam logic [12:0] MODE = 13'h0037;
  localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, AREF = 4'b0001, LMR = 4'b0000;
  localparam int PRE_AT  = IW;
  localparam int A1_AT   = IW + 1 + TRP;
  localparam int A2_AT   = A1_AT + TRFC + 1;
  localparam int LMR_AT  = A2_AT + TRFC + 1;
  localparam int DONE_AT = LMR_AT + 1 + TMRD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ref_ack = 1'b0;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic        init_done, ref_req, ref_busy, ref_overflow;

  int total = 0;
  int bad = 0;

  // reference model state: cycle index since release, owed refreshes, last AREF cycle
  int          m_k = -1;
  int          m_owed = 0;
  bit          m_ovf = 1'b0;
  int          m_aref = -1000;
  logic [3:0]  exp_cmd = NOP;
  logic [12:0] exp_addr = '0;
  logic        exp_done = 1'b0, exp_req = 1'b0, exp_busy = 1'b0;

  sdram_init_refresh_ctrl #(
    .INIT_WAIT(IW), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD), .REF_PERIOD(P), .MODE_REG(MODE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ref_ack(ref_ack),
    .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .init_done(init_done), .ref_req(ref_req), .ref_busy(ref_busy), .ref_overflow(ref_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] dut_vec();
    return {sdram_cmd, sdram_ba, sdram_addr, init_done, ref_req, ref_busy, ref_overflow};
  endfunction

  function automatic logic [22:0] exp_vec();
    return {exp_cmd, 2'b00, exp_addr, exp_done, exp_req, exp_busy, m_ovf};
  endfunction

  task automatic model_edge(input logic r, input logic a);
    bit grant, tick;
    if (!r) begin
      m_k = -1; m_owed = 0; m_ovf = 1'b0; m_aref = -1000;
      exp_cmd = NOP; exp_addr = '0; exp_done = 1'b0; exp_req = 1'b0; exp_busy = 1'b0;
      return;
    end
    grant = exp_req && a;
    m_k++;
    exp_cmd = NOP; exp_addr = '0; exp_req = 1'b0; exp_busy = 1'b0;
    if (m_k < DONE_AT) begin
      exp_done = 1'b0;
      if (m_k == PRE_AT) begin exp_cmd = PRE; exp_addr = 13'h0400; end
      else if (m_k == A1_AT || m_k == A2_AT) exp_cmd = AREF;
      else if (m_k == LMR_AT) begin exp_cmd = LMR; exp_addr = MODE; end
    end else begin
      exp_done = 1'b1;
      tick = (m_k > DONE_AT) && ((m_k - DONE_AT) % P == 0);
      if (grant) m_aref = m_k;
      if (tick && !grant) begin
        if (m_owed == 3) m_ovf = 1'b1;
        else m_owed++;
      end else if (grant && !tick) begin
        m_owed--;
      end
      exp_busy = (m_k >= m_aref) && (m_k <= m_aref + TRFC);
      if (m_k == m_aref) exp_cmd = AREF;
      exp_req = (m_owed > 0) && !exp_busy;
    end
  endtask

  // drive inputs for the next edge, let the model see the same edge, then sample at negedge
  task automatic cycle(input logic r, input logic a);
    rst_n = r;
    ref_ack = a;
    @(posedge clk);
    model_edge(r, a);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)));
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_vec cyc=%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
    total++;
    if ({sdram_cmd, sdram_addr, init_done, ref_req, ref_busy, ref_overflow} !== {NOP, 13'd0, 4'b0000}) begin
      bad++; $display("FAIL reset_values got cmd=%b addr=%h flags=%b%b%b%b want cmd=0111 addr=0 flags=0000",
                      sdram_cmd, sdram_addr, init_done, ref_req, ref_busy, ref_overflow);
    end
  endtask

  task automatic test_init_sequence();
    int pre_c, lmr_c, done_c;
    int aref_q[$];
    logic [12:0] pre_addr, lmr_addr;
    pre_c = -1; lmr_c = -1; done_c = -1; pre_addr = '0; lmr_addr = '0;
    do begin
      cycle(1'b1, 1'b0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL init_vec cyc=%0d got=%h want=%h", m_k, dut_vec(), exp_vec());
      end
      if (sdram_cmd === PRE && pre_c < 0) begin pre_c = m_k; pre_addr = sdram_addr; end
      if (sdram_cmd === AREF) aref_q.push_back(m_k);
      if (sdram_cmd === LMR && lmr_c < 0) begin lmr_c = m_k; lmr_addr = sdram_addr; end
      if (init_done === 1'b1 && done_c < 0) done_c = m_k;
    end while (m_k < 40);
    total++;
    if (pre_c != 10 || pre_addr[10] !== 1'b1) begin
      bad++; $display("FAIL init_pre got cyc=%0d addr=%h want cyc=10 addr[10]=1", pre_c, pre_addr);
    end
    total++;
    if (aref_q.size() != 2 || aref_q[0] != 13 || aref_q[1] != 21) begin
      bad++; $display("FAIL init_aref got n=%0d first=%0d second=%0d want 13,21",
                      aref_q.size(), aref_q.size() > 0 ? aref_q[0] : -1, aref_q.size() > 1 ? aref_q[1] : -1);
    end
    total++;
    if (lmr_c != 29 || lmr_addr !== 13'h0037) begin
      bad++; $display("FAIL init_lmr got cyc=%0d addr=%h want cyc=29 addr=0037", lmr_c, lmr_addr);
    end
    total++;
    if (done_c != 32) begin
      bad++; $display("FAIL init_done_cycle got=%0d want=32", done_c);
    end
  endtask

  task automatic test_refresh_ack_high();
    int req_c, busy_n;
    int aref_q[$];
    bit ovf_seen;
    req_c = -1; busy_n = 0; ovf_seen = 1'b0;
    cycle(1'b0, 1'b0);
    do begin
      cycle(1'b1, 1'b1);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL ackhigh_vec cyc=%0d got=%h want=%h", m_k, dut_vec(), exp_vec());
      end
      if (ref_req === 1'b1 && req_c < 0) req_c = m_k;
      if (sdram_cmd === AREF && m_k >= 32) aref_q.push_back(m_k);
      if (ref_busy === 1'b1 && m_k <= 100) busy_n++;
      if (ref_overflow === 1'b1) ovf_seen = 1'b1;
    end while (m_k < 140);
    total++;
    if (req_c != 82) begin bad++; $display("FAIL ackhigh_first_req got=%0d want=82", req_c); end
    total++;
    if (aref_q.size() != 2 || aref_q[0] != 83 || aref_q[1] != 133) begin
      bad++; $display("FAIL ackhigh_aref got n=%0d first=%0d want n=2 at 83,133",
                      aref_q.size(), aref_q.size() > 0 ? aref_q[0] : -1);
    end
    total++;
    if (busy_n != 8) begin bad++; $display("FAIL ackhigh_busy_len got=%0d want=8", busy_n); end
    total++;
    if (ovf_seen) begin bad++; $display("FAIL ackhigh_overflow got=1 want=0"); end
  endtask

  task automatic test_overflow_and_reset_mid_refresh();
    int ovf_c, pre_c;
    int aref_q[$];
    bit ovf_seen;
    ovf_c = -1; pre_c = -1; ovf_seen = 1'b0;
    cycle(1'b0, 1'b0);
    do begin
      cycle(1'b1, 1'b0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL ovf_vec cyc=%0d got=%h want=%h", m_k, dut_vec(), exp_vec());
      end
      if (ref_overflow === 1'b1 && ovf_c < 0) ovf_c = m_k;
    end while (m_k < 232);
    total++;
    if (ovf_c != 232) begin bad++; $display("FAIL ovf_set_cycle got=%0d want=232", ovf_c); end
    do begin
      cycle(1'b1, 1'b1);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL drain_vec cyc=%0d got=%h want=%h", m_k, dut_vec(), exp_vec());
      end
      if (sdram_cmd === AREF) aref_q.push_back(m_k);
    end while (m_k < 281);
    // each drained refresh is REF_CMD, T_RFC wait cycles, then one IDLE cycle carrying the request
    total++;
    if (aref_q.size() != 3 || aref_q[0] != 233 || aref_q[1] - aref_q[0] != TRFC + 2 ||
        aref_q[2] - aref_q[1] != TRFC + 2) begin
      bad++; $display("FAIL drain_arefs got n=%0d first=%0d want n=3 first=233 step=%0d",
                      aref_q.size(), aref_q.size() > 0 ? aref_q[0] : -1, TRFC + 2);
    end
    do cycle(1'b1, 1'b1); while (m_k < 286);
    total++;
    if (ref_busy !== 1'b1 || sdram_cmd !== NOP || ref_overflow !== 1'b1) begin
      bad++; $display("FAIL in_ref_wait got busy=%b cmd=%b ovf=%b want busy=1 cmd=0111 ovf=1",
                      ref_busy, sdram_cmd, ref_overflow);
    end
    cycle(1'b0, 1'b1);
    total++;
    if (dut_vec() !== {NOP, 2'b00, 13'd0, 4'b0000}) begin
      bad++; $display("FAIL reset_in_refresh got=%h want=%h", dut_vec(), {NOP, 2'b00, 13'd0, 4'b0000});
    end
    do begin
      cycle(1'b1, 1'b0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL rerun_vec cyc=%0d got=%h want=%h", m_k, dut_vec(), exp_vec());
      end
      if (sdram_cmd === PRE && pre_c < 0) pre_c = m_k;
      if (ref_overflow === 1'b1) ovf_seen = 1'b1;
    end while (m_k < 40);
    total++;
    if (pre_c != 10 || ovf_seen) begin
      bad++; $display("FAIL rerun_after_refresh_reset got pre=%0d ovf=%b want pre=10 ovf=0", pre_c, ovf_seen);
    end
  endtask

  task automatic test_reset_mid_init();
    int pre_c;
    pre_c = -1;
    cycle(1'b0, 1'b0);
    do cycle(1'b1, 1'b0); while (m_k < 24);
    cycle(1'b0, 1'b0);
    total++;
    if (dut_vec() !== {NOP, 2'b00, 13'd0, 4'b0000}) begin
      bad++; $display("FAIL reset_mid_init got=%h want=%h", dut_vec(), {NOP, 2'b00, 13'd0, 4'b0000});
    end
    do begin
      cycle(1'b1, 1'b0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL midinit_vec cyc=%0d got=%h want=%h", m_k, dut_vec(), exp_vec());
      end
      if (sdram_cmd === PRE && pre_c < 0) pre_c = m_k;
    end while (m_k < 14);
    total++;
    if (pre_c != 10) begin bad++; $display("FAIL midinit_pre got=%0d want=10", pre_c); end
  endtask

  task automatic test_tick_on_ref_cmd();
    int n_aref;
    n_aref = 0;
    cycle(1'b0, 1'b0);
    do cycle(1'b1, 1'b0); while (m_k < 131);
    cycle(1'b1, 1'b1);
    total++;
    if (sdram_cmd !== AREF || ref_busy !== 1'b1) begin
      bad++; $display("FAIL tick_ref_cmd cyc=%0d got cmd=%b busy=%b want cmd=0001 busy=1", m_k, sdram_cmd, ref_busy);
    end
    do cycle(1'b1, 1'b0); while (m_k < 139);
    total++;
    if (ref_req !== 1'b0) begin bad++; $display("FAIL tick_req_in_wait got=%b want=0", ref_req); end
    cycle(1'b1, 1'b0);
    total++;
    if (ref_req !== 1'b1 || ref_busy !== 1'b0) begin
      bad++; $display("FAIL tick_req_reassert got req=%b busy=%b want req=1 busy=0", ref_req, ref_busy);
    end
    do cycle(1'b1, 1'b0); while (m_k < 185);
    do begin
      cycle(1'b1, 1'b1);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL tick_vec cyc=%0d got=%h want=%h", m_k, dut_vec(), exp_vec());
      end
      if (sdram_cmd === AREF) n_aref++;
    end while (m_k < 220);
    // one refresh still owed after the coincident tick, one more from the tick at 182
    total++;
    if (n_aref != 2) begin bad++; $display("FAIL tick_owed_drain got=%0d want=2", n_aref); end
  endtask

  task automatic test_ack_ignored();
    int n_init, n_idle;
    logic a;
    n_init = 0; n_idle = 0;
    cycle(1'b0, 1'b1);
    do begin
      a = ($urandom_range(0, 1) == 1);
      cycle(1'b1, a);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL ignore_vec cyc=%0d got=%h want=%h", m_k, dut_vec(), exp_vec());
      end
      if (sdram_cmd === AREF && m_k < 32) n_init++;
      if (sdram_cmd === AREF && m_k >= 32) n_idle++;
    end while (m_k < 81);
    total++;
    if (n_init != 2 || n_idle != 0) begin
      bad++; $display("FAIL ack_ignored got init_arefs=%0d idle_arefs=%0d want 2 and 0", n_init, n_idle);
    end
  endtask

  task automatic test_random();
    logic r, a;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 299) != 0);
      a = ($urandom_range(0, 2) == 0);
      cycle(r, a);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_vec i=%0d cyc=%0d got=%h want=%h", i, m_k, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_init_sequence();
    test_refresh_ack_high();
    test_overflow_and_reset_mid_refresh();
    test_reset_mid_init();
    test_tick_on_ref_cmd();
    test_ack_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
